// File: rtl/glb_skew_scheduler.sv
//------------------------------------------------------------------------------
// glb_skew_scheduler: reads the per-row GLB FIFOs with an r-cycle skew so the
// data enters the systolic PE array as a diagonal wavefront.
// Optional build macro: GLB_SKEW_PERF_EN adds the stall_cnt_o counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module glb_skew_scheduler #(
   parameter int PE_SIZE   = 16,
   parameter int LEN_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [LEN_WIDTH-1:0] len_i,
   input  logic                 abort_i,
   input  logic                 hold_i,
   input  logic [PE_SIZE-1:0]   empty_i,
   output logic [PE_SIZE-1:0]   rden_o,
   output logic [PE_SIZE-1:0]   row_valid_o,
   output logic                 busy_o,
`ifdef GLB_SKEW_PERF_EN
   output logic [31:0]          stall_cnt_o,
`endif
   output logic                 done_o
);

   localparam int TW = LEN_WIDTH + 1;
   localparam logic [TW-1:0] LAST_OFS = TW'(PE_SIZE - 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state, state_nx;
   logic [TW-1:0]        t, t_nx;
   logic [LEN_WIDTH-1:0] len_q, len_nx;
   logic [PE_SIZE-1:0]   active;
   logic [PE_SIZE-1:0]   rden;
   logic                 stall;
   logic                 start_ok;

   // Row r owns steps [r, r+len_q); the sum fits in TW bits so nothing wraps.
   generate
      for (genvar r = 0; r < PE_SIZE; r++) begin : g_row
         localparam logic [TW-1:0] ROW = TW'(r);
         assign active[r] = (state == S_RUN) && (t >= ROW) && (t < ROW + {1'b0, len_q});
      end
   endgenerate

   // One empty active row freezes every row so the diagonal stays intact.
   assign stall    = hold_i | (|(active & empty_i));
   assign rden     = (abort_i || stall) ? '0 : active;
   assign start_ok = (state == S_IDLE) && start_i && !abort_i;

   assign rden_o = rden;
   assign busy_o = (state == S_RUN) || (state == S_DONE);
   assign done_o = (state == S_DONE);

   always_comb begin
      state_nx = state;
      t_nx     = t;
      len_nx   = len_q;
      if (abort_i) begin
         state_nx = S_IDLE;
         t_nx     = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  len_nx   = len_i;
                  t_nx     = '0;
                  state_nx = (len_i != '0) ? S_RUN : S_DONE;
               end
            end
            S_RUN: begin
               if (!stall) begin
                  t_nx = t + 1'b1;
                  if (t == {1'b0, len_q} + LAST_OFS) begin
                     state_nx = S_DONE;
                  end
               end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         t           <= '0;
         len_q       <= '0;
         row_valid_o <= '0;
      end else begin
         state       <= state_nx;
         t           <= t_nx;
         len_q       <= len_nx;
         row_valid_o <= abort_i ? '0 : rden;
      end
   end

`ifdef GLB_SKEW_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_o <= '0;
      end else if (start_ok) begin
         stall_cnt_o <= '0;
      end else if ((state == S_RUN) && stall && (stall_cnt_o != 32'hFFFF_FFFF)) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

`default_nettype wire

// File: tb/tb_glb_skew_scheduler.sv
//------------------------------------------------------------------------------
// tb_glb_skew_scheduler: directed and randomized checks against a row-credit
// reference model (row r reads while it owes data and row r-1 is ahead of it).
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_glb_skew_scheduler;

   localparam int PE = 4;
   localparam int LW = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          hold  = 1'b0;
   logic [LW-1:0] len   = '0;
   logic [PE-1:0] empty = '0;
   logic [PE-1:0] rden, row_valid;
   logic          busy, done;
`ifdef GLB_SKEW_PERF_EN
   logic [31:0]   stall_cnt;
`endif

   glb_skew_scheduler #(.PE_SIZE(PE), .LEN_WIDTH(LW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .len_i       (len),
      .abort_i     (abort),
      .hold_i      (hold),
      .empty_i     (empty),
      .rden_o      (rden),
      .row_valid_o (row_valid),
      .busy_o      (busy),
`ifdef GLB_SKEW_PERF_EN
      .stall_cnt_o (stall_cnt),
`endif
      .done_o      (done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: phase 0=idle 1=run 2=done, per-row read credits.
   int            m_phase = 0;
   int            m_len   = 0;
   int            m_reads [PE];
   int            m_stalls = 0;
   logic [PE-1:0] m_prev  = '0;
   int            obs     [PE];

   logic [PE-1:0] s_rden;
   logic          s_done, s_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at posedge+1 with inputs set; checks mid-cycle, then advances the model.
   task automatic cyc();
      logic [PE-1:0] act;
      logic [PE-1:0] er;
      logic          stl;
      #3;
      for (int r = 0; r < PE; r++) begin
         act[r] = (m_phase == 1) && (m_reads[r] < m_len);
         if (r > 0 && !(m_reads[r-1] > m_reads[r])) act[r] = 1'b0;
      end
      stl = hold | (|(act & empty));
      er  = (abort || stl) ? '0 : act;
      s_rden = rden; s_done = done; s_busy = busy;
      check("rden", rden, er);
      check("row_valid", row_valid, m_prev);
      check("busy", busy, m_phase != 0);
      check("done", done, m_phase == 2);
`ifdef GLB_SKEW_PERF_EN
      check("stall_cnt", stall_cnt, m_stalls);
`endif
      for (int r = 0; r < PE; r++) obs[r] += int'(rden[r]);
      @(posedge clk);
      m_prev = er;
      if (m_phase == 1 && stl) m_stalls++;
      if (abort) begin
         m_phase = 0;
      end else begin
         case (m_phase)
            0: if (start) begin
                  m_stalls = 0;
                  m_len    = int'(len);
                  for (int r = 0; r < PE; r++) begin m_reads[r] = 0; obs[r] = 0; end
                  m_phase  = (len != 0) ? 1 : 2;
               end
            1: if (!stl) begin
                  for (int r = 0; r < PE; r++) if (act[r]) m_reads[r]++;
                  if (m_reads[PE-1] == m_len) begin
                     m_phase = 2;
                     for (int r = 0; r < PE; r++) check("row_total", obs[r], m_len);
                  end
               end
            default: m_phase = 0;
         endcase
      end
      #1;
   endtask

   task automatic run_to_done(output int n);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         cyc();
         n++;
         if (s_done) break;
      end
      if (!s_done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_rden", rden, 0);
      check("rst_row_valid", row_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
`ifdef GLB_SKEW_PERF_EN
      check("rst_stall_cnt", stall_cnt, 0);
`endif
      m_phase = 0; m_prev = '0; m_stalls = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [PE-1:0] seq1 [7];
   int            n;

   initial begin
      seq1 = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};
      for (int r = 0; r < PE; r++) begin m_reads[r] = 0; obs[r] = 0; end
      #1;
      do_reset();

      // Basic tile
      start = 1; len = 3; cyc(); start = 0;
      for (int k = 0; k < 7; k++) begin
         cyc();
         check("t1_rden", s_rden, seq1[k]);
         check("t1_done", s_done, k == 6);
         check("t1_busy", s_busy, 1);
      end
      cyc();
      check("t1_idle", s_busy, 0);

      // Empty stall on row 1 at t=2
      start = 1; len = 3; cyc(); start = 0;
      cyc(); cyc();
      empty = 4'b0010;
      cyc(); check("t2_stall0", s_rden, 0);
      cyc(); check("t2_stall1", s_rden, 0);
      empty = '0;
      cyc(); check("t2_resume", s_rden, 4'h7);
      run_to_done(n);
      check("t2_latency", 5 + n, 9);
`ifdef GLB_SKEW_PERF_EN
      check("t6_cnt_after_done", stall_cnt, 2);
      start = 1; len = 2; cyc(); start = 0;
      check("t6_cnt_cleared", stall_cnt, 0);
      run_to_done(n);
`endif
      cyc();

      // Hold at t=4
      start = 1; len = 3; cyc(); start = 0;
      repeat (4) cyc();
      hold = 1;
      repeat (3) begin cyc(); check("t3_hold", s_rden, 0); end
      hold = 0;
      run_to_done(n);
      for (int r = 0; r < PE; r++) check("t3_total", obs[r], 3);
      cyc();

      // Zero length
      start = 1; len = 0; cyc(); start = 0;
      cyc(); check("t4_done", s_done, 1); check("t4_rden", s_rden, 0);
      cyc(); check("t4_after", s_done, 0);

      // Abort at t=3, then start+abort together in idle
      start = 1; len = 3; cyc(); start = 0;
      repeat (3) cyc();
      abort = 1;
      cyc(); check("t5_abort_rden", s_rden, 0);
      start = 1;
      cyc();
      abort = 0; start = 0;
      repeat (4) begin
         cyc();
         check("t5_idle_busy", s_busy, 0);
         check("t5_no_done", s_done, 0);
      end

      // Asynchronous reset mid-tile
      start = 1; len = 5; cyc(); start = 0;
      repeat (3) cyc();
      do_reset();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 3) == 0);
         len   = LW'($urandom_range(0, 15));
         hold  = ($urandom_range(0, 9) == 0);
         abort = ($urandom_range(0, 99) == 0);
         for (int r = 0; r < PE; r++) empty[r] = ($urandom_range(0, 7) == 0);
         cyc();
      end
      start = 0; hold = 0; abort = 0; empty = '0;
      repeat (25) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
